access_code_checker: RTL and testbench

//  Upstream qualifier for the access-control FSM. Collects keypad digits, compares the

---
 rtl/access_code_checker_pkg.sv | 20 ++
 rtl/access_code_checker_lockout_timer.sv | 29 ++
 rtl/access_code_checker.sv | 149 ++++++++++++++
 tb/tb_access_code_checker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/access_code_checker_pkg.sv
// Shared definitions for the access code checker: state encodings and a
// width helper used to size the digit/fail counters and the lockout timer.
package access_code_checker_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_CHECK  = 2'd1,
    ST_GOOD   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/access_code_checker_lockout_timer.sv
// Down-counter for the lockout window: load a start value, count down to
// zero while enabled, and flag when zero has been reached.
module lockout_timer #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         done
);

  logic [W-1:0] count_reg;

  // Load has priority over counting; the counter parks at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/access_code_checker.sv
// Keypad code qualifier: gathers DIGITS digits, compares them against CODE,
// tracks consecutive failures and holds a timed lockout after MAX_FAILS.
import access_code_checker_pkg::*;

module access_code_checker #(
  parameter int                           DIGITS      = 4,
  parameter int                           DIGIT_W     = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]    CODE        = 16'h1234,
  parameter int                           MAX_FAILS   = 3,
  parameter int                           LOCK_CYCLES = 1000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                digit_valid,
  input  logic [DIGIT_W-1:0]                  digit,
  input  logic                                clear,
  output logic                                Correct,
  output logic                                Blocked,
  output logic                                fail_pulse,
  output logic [clog2w(DIGITS+1)-1:0]         digit_cnt,
  output logic [clog2w(MAX_FAILS+1)-1:0]      fail_cnt
);

  localparam int TOT_W = DIGITS * DIGIT_W;
  localparam int CW    = clog2w(DIGITS + 1);
  localparam int FW    = clog2w(MAX_FAILS + 1);
  localparam int TW    = clog2w(LOCK_CYCLES);

  state_t           state_reg, state_next;
  logic [TOT_W-1:0] shift_reg, shift_next;
  logic [CW-1:0]    digit_cnt_reg, digit_cnt_next;
  logic [FW-1:0]    fail_cnt_reg, fail_cnt_next;
  logic             fail_pulse_reg, fail_pulse_next;
  logic             timer_load, timer_en, timer_done;
  logic [DIGITS-1:0] digit_eq;
  logic             code_match;

  // Per-digit comparison against the stored code; all digits must agree.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit_cmp
      assign digit_eq[gi] = (shift_reg[gi*DIGIT_W +: DIGIT_W] == CODE[gi*DIGIT_W +: DIGIT_W]);
    end
  endgenerate

  assign code_match = &digit_eq;

  lockout_timer #(
    .W (TW)
  ) u_lockout_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (TW'(LOCK_CYCLES - 1)),
    .enable     (timer_en),
    .done       (timer_done)
  );

  // State, entry buffer, counters and strobe registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_ENTRY;
      shift_reg      <= '0;
      digit_cnt_reg  <= '0;
      fail_cnt_reg   <= '0;
      fail_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      digit_cnt_reg  <= digit_cnt_next;
      fail_cnt_reg   <= fail_cnt_next;
      fail_pulse_reg <= fail_pulse_next;
    end
  end

  // Next-state logic: digit collection, one-cycle verdict, hold and lockout.
  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    digit_cnt_next  = digit_cnt_reg;
    fail_cnt_next   = fail_cnt_reg;
    fail_pulse_next = 1'b0;
    timer_load      = 1'b0;
    timer_en        = 1'b0;

    case (state_reg)
      ST_ENTRY: begin
        if (clear) begin
          digit_cnt_next = '0;
          shift_next     = '0;
        end else if (digit_valid) begin
          shift_next = (shift_reg << DIGIT_W) | TOT_W'(digit);
          if (digit_cnt_reg == CW'(DIGITS - 1)) begin
            digit_cnt_next = '0;
            state_next     = ST_CHECK;
          end else begin
            digit_cnt_next = digit_cnt_reg + CW'(1);
          end
        end
      end

      ST_CHECK: begin
        // The buffered entry is consumed here whatever the verdict.
        shift_next = '0;
        if (code_match) begin
          state_next    = ST_GOOD;
          fail_cnt_next = '0;
        end else if ((int'(fail_cnt_reg) + 1) < MAX_FAILS) begin
          state_next      = ST_ENTRY;
          fail_cnt_next   = fail_cnt_reg + FW'(1);
          fail_pulse_next = 1'b1;
        end else begin
          state_next      = ST_LOCKED;
          fail_cnt_next   = FW'(MAX_FAILS);
          fail_pulse_next = 1'b1;
          timer_load      = 1'b1;
        end
      end

      ST_GOOD: begin
        if (clear) begin
          state_next = ST_ENTRY;
        end
      end

      ST_LOCKED: begin
        timer_en = 1'b1;
        if (timer_done) begin
          state_next    = ST_ENTRY;
          fail_cnt_next = '0;
        end
      end

      default: begin
        state_next     = ST_ENTRY;
        shift_next     = '0;
        digit_cnt_next = '0;
        fail_cnt_next  = '0;
      end
    endcase
  end

  assign Correct    = (state_reg == ST_GOOD);
  assign Blocked    = (state_reg == ST_LOCKED);
  assign fail_pulse = fail_pulse_reg;
  assign digit_cnt  = digit_cnt_reg;
  assign fail_cnt   = fail_cnt_reg;

endmodule

// File: tb/tb_access_code_checker.sv
// Directed bench for access_code_checker with default parameters
// (code 1234, three strikes, 1000-cycle lockout).
module tb_access_code_checker;

  logic       clock;
  logic       reset;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic       Correct;
  logic       Blocked;
  logic       fail_pulse;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;

  int vectors;
  int miscompares;

  access_code_checker dut (
    .clock       (clock),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
    .clear       (clear),
    .Correct     (Correct),
    .Blocked     (Blocked),
    .fail_pulse  (fail_pulse),
    .digit_cnt   (digit_cnt),
    .fail_cnt    (fail_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
  endtask

  // Four digits then one more edge: the verdict is visible on return.
  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    send_digit(a);
    send_digit(b);
    send_digit(c);
    send_digit(d);
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int n;
    int stray;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    digit_valid = 1'b0;
    digit       = 4'h0;
    clear       = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_correct", 32'(Correct), 32'd0);
    check("rst_blocked", 32'(Blocked), 32'd0);
    check("rst_pulse", 32'(fail_pulse), 32'd0);
    check("rst_dcnt", 32'(digit_cnt), 32'd0);
    check("rst_fcnt", 32'(fail_cnt), 32'd0);

    // 1: correct code, Correct one edge after the CHECK cycle
    send_digit(4'h1);
    check("t1_dcnt1", 32'(digit_cnt), 32'd1);
    send_digit(4'h2);
    check("t1_dcnt2", 32'(digit_cnt), 32'd2);
    send_digit(4'h3);
    check("t1_dcnt3", 32'(digit_cnt), 32'd3);
    send_digit(4'h4);
    check("t1_dcnt_wrap", 32'(digit_cnt), 32'd0);
    check("t1_correct_early", 32'(Correct), 32'd0);
    tick();
    check("t1_correct", 32'(Correct), 32'd1);
    check("t1_fcnt", 32'(fail_cnt), 32'd0);
    check("t1_pulse", 32'(fail_pulse), 32'd0);
    send_digit(4'h9);
    check("t1_good_hold", 32'(Correct), 32'd1);
    check("t1_good_dcnt", 32'(digit_cnt), 32'd0);
    do_clear();
    check("t1_clear", 32'(Correct), 32'd0);

    // 2: single wrong entry
    enter4(4'h1, 4'h2, 4'h3, 4'h5);
    check("t2_pulse", 32'(fail_pulse), 32'd1);
    check("t2_fcnt", 32'(fail_cnt), 32'd1);
    check("t2_correct", 32'(Correct), 32'd0);
    check("t2_blocked", 32'(Blocked), 32'd0);
    tick();
    check("t2_pulse_end", 32'(fail_pulse), 32'd0);
    send_digit(4'h1);
    check("t2_entry_dcnt", 32'(digit_cnt), 32'd1);
    do_clear();
    check("t2_clear_dcnt", 32'(digit_cnt), 32'd0);

    // 5: second wrong, then correct resets the count; later single wrong
    enter4(4'h0, 4'h0, 4'h0, 4'h0);
    check("t5_fcnt2", 32'(fail_cnt), 32'd2);
    check("t5_no_lock", 32'(Blocked), 32'd0);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    check("t5_correct", 32'(Correct), 32'd1);
    check("t5_fcnt0", 32'(fail_cnt), 32'd0);
    do_clear();
    enter4(4'h4, 4'h3, 4'h2, 4'h1);
    check("t5_fcnt1", 32'(fail_cnt), 32'd1);
    check("t5_blocked", 32'(Blocked), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_fcnt", 32'(fail_cnt), 32'd0);

    // 3: three wrong entries -> lockout of exactly 1000 cycles
    enter4(4'h1, 4'h1, 4'h1, 4'h1);
    enter4(4'h2, 4'h2, 4'h2, 4'h2);
    check("t3_fcnt2", 32'(fail_cnt), 32'd2);
    enter4(4'h1, 4'h2, 4'h3, 4'h0);
    check("t3_blocked", 32'(Blocked), 32'd1);
    check("t3_pulse", 32'(fail_pulse), 32'd1);
    check("t3_fcnt_sat", 32'(fail_cnt), 32'd3);
    check("t3_correct", 32'(Correct), 32'd0);
    n     = 1;
    stray = 0;
    for (int i = 0; i < 2000; i++) begin
      digit_valid = i[0];
      digit       = 4'(i);
      clear       = (i % 7 == 3);
      tick();
      if (!Blocked) break;
      n++;
      if (digit_cnt != 3'd0 || Correct) stray++;
    end
    digit_valid = 1'b0;
    clear       = 1'b0;
    check("t3_lock_len", 32'(n), 32'd1000);
    check("t3_lock_ignored", 32'(stray), 32'd0);
    check("t3_after_fcnt", 32'(fail_cnt), 32'd0);
    check("t3_after_dcnt", 32'(digit_cnt), 32'd0);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    check("t3_after_correct", 32'(Correct), 32'd1);
    do_clear();

    // 4: clear beats digit_valid in the same cycle
    send_digit(4'h1);
    send_digit(4'h2);
    check("t4_dcnt2", 32'(digit_cnt), 32'd2);
    clear       = 1'b1;
    digit_valid = 1'b1;
    digit       = 4'h3;
    tick();
    clear       = 1'b0;
    digit_valid = 1'b0;
    check("t4_clear_wins", 32'(digit_cnt), 32'd0);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    check("t4_correct", 32'(Correct), 32'd1);
    do_clear();

    // 6: reset in the middle of a lockout
    enter4(4'h9, 4'h9, 4'h9, 4'h9);
    enter4(4'h9, 4'h9, 4'h9, 4'h9);
    enter4(4'h9, 4'h9, 4'h9, 4'h9);
    check("t6_blocked", 32'(Blocked), 32'd1);
    for (int i = 0; i < 499; i++) tick();
    check("t6_still_blocked", 32'(Blocked), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_blocked", 32'(Blocked), 32'd0);
    check("t6_rst_fcnt", 32'(fail_cnt), 32'd0);
    send_digit(4'h1);
    check("t6_dcnt1", 32'(digit_cnt), 32'd1);
    send_digit(4'h2);
    send_digit(4'h3);
    send_digit(4'h4);
    tick();
    check("t6_correct", 32'(Correct), 32'd1);
    check("t6_blocked_end", 32'(Blocked), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
